ad9970_sync_decode: RTL and testbench
=====================================

// Module: ad9970_sync_decode
// PURPOSE
//  Sits downstream of the AD9970 LVDS deserializer. Consumes the deserializer's parallel 16-bit words,
//  hunts for the AD9970 line sync sequence (N consecutive sync words) and extracts one line of
//  14-bit pixels with a line-valid strobe for the CCD pixel pipeline. Tracks sync lock and flags a
//  sync timeout.
// PARAMETERS
//  DATA_WD     16   deserialized word width
//  PIX_WD      14   output pixel width
//  CNT_WD      13   pixel/length counter width (line length up to 8191)
//  TMO_WD      16   timeout counter width
// PORTS
//  clk               in   1        pixel-word clock (deserializer output domain)
//  reset             in   1        synchronous, active-high
//  i_start_acquisit  in   1        1 = decode enabled; 0 = forced to HUNT
//  iv_deser_data     in   DATA_WD  deserialized word
//  i_deser_valid     in   1        iv_deser_data qualifier; every stall cycle is ignored
//  iv_sync_word      in   DATA_WD  sync word value (e.g. 16'h8421)
//  iv_sync_len       in   3        required consecutive sync words, 1..7 (0 treated as 1)
//  iv_line_pix       in   CNT_WD   pixels per line following sync
//  i_align_right     in   1        1: pixel = word[13:0]; 0: pixel = word[15:2]
//  iv_timeout        in   TMO_WD   max valid words without a complete sync; 0 disables
//  ov_pix_data       out  PIX_WD   pixel data
//  o_lval            out  1        pixel valid / line active
//  o_line_done       out  1        1-cycle pulse after last pixel of a line
//  o_sync_lock       out  1        sync locked
//  o_sync_err        out  1        1-cycle pulse on timeout
// BEHAVIOUR
//  Reset: all outputs 0, state HUNT, counters 0. Reset dominates every other input.
//  Config (sync_word, sync_len, line_pix, align) is shadowed on every entry to HUNT; it is stable for a line.
//  Only cycles with i_deser_valid=1 advance state or counters.
//  FSM:
//   HUNT: word==sync_word -> match count = 1; if sync_len==1 -> DATA, else -> SYNC.
//   SYNC: matching word -> count++; when count==sync_len -> DATA. Non-matching word -> HUNT, count 0.
//   DATA: each valid word is a pixel (pixel values equal to sync_word are data, not sync); pixel counter++;
//         the word carrying pixel index line_pix-1 -> HUNT.
//  Entering DATA with line_pix==0 -> immediate HUNT, o_line_done pulses, no o_lval.
//  Output latency 1 clk: pixel word at cycle n -> ov_pix_data/o_lval=1 at n+1.
//   o_lval=0 on any cycle without a DATA-state valid word (gaps allowed mid-line).
//   ov_pix_data holds its last value when o_lval=0.
//  o_line_done: pulses in the cycle after the last pixel's o_lval (n+2). o_sync_lock set on the same
//   edge; cleared only by o_sync_err, reset, or i_start_acquisit=0.
//  Timeout: counts valid words while in HUNT/SYNC.
//   Reaching iv_timeout -> o_sync_err pulse 1 clk, lock cleared, counter restarts from 0.
//   The counter clears on entering DATA.
//  i_start_acquisit=0: next clk -> HUNT, o_lval=0, lock=0, counters 0. A partial line is discarded
//   with no o_line_done.
// CONFIGURATION
//  AD9970_LINE_CNT_EN:
//   Defined: adds input i_frame_start (1-cycle pulse, clears count) and output ov_line_cnt[15:0].
//    ov_line_cnt increments on each o_line_done and wraps at 16'hFFFF -> 0.
//    On the same cycle as o_line_done, i_frame_start wins: count becomes 0.
//   Undefined: neither port exists and no counter logic is built.
// TESTING
//  7x 16'h8421, sync_len=7, line_pix=1292, right-aligned ramp 0..1291 ->
//   o_lval high for 1292 valid cycles, data 0..1291, one o_line_done, o_sync_lock=1.
//  6x 8421 then 16'h1234, then 7x 8421 + line -> first run rejected, line decoded only after second run,
//   no o_sync_err.
//  i_deser_valid toggled 1/0 through the line -> o_lval mirrors the gaps, 1292 pixels total, data intact.
//  iv_timeout=100, no sync words for 250 valid words -> o_sync_err pulses at words 100 and 200,
//   lock stays 0.
//  i_start_acquisit dropped at pixel 500 -> o_lval=0 next clk, no o_line_done.
//   Re-enable + full sync -> clean line.
//  i_align_right=0, word 16'hABCD -> ov_pix_data=14'h2AF3.
//   With AD9970_LINE_CNT_EN: 3 lines -> ov_line_cnt=3; i_frame_start -> 0.

Source files
------------

// File: rtl/ad9970_sync_decode_if.sv
// Word/pixel bus between the AD9970 deserializer side and the line sync decoder.
interface ad9970_sync_decode_if #(
   parameter int DATA_WD = 16,
   parameter int PIX_WD  = 14
);
   logic [DATA_WD-1:0] iv_deser_data;
   logic               i_deser_valid;
   logic [PIX_WD-1:0]  ov_pix_data;
   logic               o_lval;
   logic               o_line_done;
   logic               o_sync_lock;
   logic               o_sync_err;

   modport master (
      output iv_deser_data, i_deser_valid,
      input  ov_pix_data, o_lval, o_line_done, o_sync_lock, o_sync_err
   );

   modport slave (
      input  iv_deser_data, i_deser_valid,
      output ov_pix_data, o_lval, o_line_done, o_sync_lock, o_sync_err
   );
endinterface

// File: rtl/ad9970_sync_decode.sv
// AD9970 line sync hunter and pixel extractor with lock tracking and sync timeout.
// Optional AD9970_LINE_CNT_EN adds i_frame_start / ov_line_cnt line counting.
//
//   state | meaning
//   HUNT  | waiting for first sync word; config shadowed on entry
//   SYNC  | counting consecutive sync words
//   DATA  | emitting line pixels
module ad9970_sync_decode #(
   parameter int DATA_WD = 16,
   parameter int PIX_WD  = 14,
   parameter int CNT_WD  = 13,
   parameter int TMO_WD  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_start_acquisit,
   input  logic [DATA_WD-1:0]  iv_sync_word,
   input  logic [2:0]          iv_sync_len,
   input  logic [CNT_WD-1:0]   iv_line_pix,
   input  logic                i_align_right,
   input  logic [TMO_WD-1:0]   iv_timeout,
`ifdef AD9970_LINE_CNT_EN
   input  logic                i_frame_start,
   output logic [15:0]         ov_line_cnt,
`endif
   ad9970_sync_decode_if.slave bus
);

   typedef enum logic [1:0] {HUNT, SYNC, DATA} state_t;

   state_t              state_q, state_d;
   logic [2:0]          match_cnt_q, match_cnt_d;
   logic [CNT_WD-1:0]   pix_cnt_q, pix_cnt_d;
   logic [TMO_WD-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [DATA_WD-1:0]  sync_word_q, sync_word_d;
   logic [2:0]          sync_len_q, sync_len_d;
   logic [CNT_WD-1:0]   line_pix_q, line_pix_d;
   logic                align_q, align_d;
   logic [PIX_WD-1:0]   pix_q, pix_d;
   logic                lval_q, lval_d;
   logic                done_pend_q, done_pend_d;
   logic                line_done_q, line_done_d;
   logic                lock_q, lock_d;
   logic                err_q, err_d;
`ifdef AD9970_LINE_CNT_EN
   logic [15:0]         line_cnt_q, line_cnt_d;
`endif

   logic       enter_data, tmo_inc, load_cfg, word_match;
   logic [2:0] len_eff;

   always_comb begin
      state_d     = state_q;
      match_cnt_d = match_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      sync_word_d = sync_word_q;
      sync_len_d  = sync_len_q;
      line_pix_d  = line_pix_q;
      align_d     = align_q;
      pix_d       = pix_q;
      lval_d      = 1'b0;
      done_pend_d = 1'b0;
      line_done_d = done_pend_q;
      lock_d      = lock_q | done_pend_q;
      err_d       = 1'b0;
      enter_data  = 1'b0;
      tmo_inc     = 1'b0;
      load_cfg    = 1'b0;
      word_match  = (bus.iv_deser_data == sync_word_q);
      len_eff     = (sync_len_q == 3'd0) ? 3'd1 : sync_len_q;

      if (!i_start_acquisit) begin
         // Partial line is dropped, including a line_done still in flight.
         state_d     = HUNT;
         match_cnt_d = '0;
         pix_cnt_d   = '0;
         tmo_cnt_d   = '0;
         line_done_d = 1'b0;
         lock_d      = 1'b0;
         load_cfg    = 1'b1;
      end else if (bus.i_deser_valid) begin
         unique case (state_q)
            HUNT: begin
               tmo_inc = 1'b1;
               if (word_match) begin
                  if (len_eff == 3'd1) begin
                     enter_data = 1'b1;
                  end else begin
                     state_d     = SYNC;
                     match_cnt_d = 3'd1;
                  end
               end
            end
            SYNC: begin
               tmo_inc = 1'b1;
               if (word_match) begin
                  if (match_cnt_q + 3'd1 == len_eff) enter_data = 1'b1;
                  else match_cnt_d = match_cnt_q + 3'd1;
               end else begin
                  state_d     = HUNT;
                  match_cnt_d = '0;
                  load_cfg    = 1'b1;
               end
            end
            DATA: begin
               lval_d = 1'b1;
               pix_d  = align_q ? bus.iv_deser_data[PIX_WD-1:0]
                                : bus.iv_deser_data[DATA_WD-1 -: PIX_WD];
               if (pix_cnt_q == line_pix_q - CNT_WD'(1)) begin
                  state_d     = HUNT;
                  pix_cnt_d   = '0;
                  done_pend_d = 1'b1;
                  load_cfg    = 1'b1;
               end else begin
                  pix_cnt_d = pix_cnt_q + CNT_WD'(1);
               end
            end
            default: state_d = HUNT;
         endcase

         if (enter_data) begin
            match_cnt_d = '0;
            tmo_cnt_d   = '0;
            pix_cnt_d   = '0;
            // Zero-length line completes immediately.
            if (line_pix_q == '0) begin
               state_d     = HUNT;
               done_pend_d = 1'b1;
               load_cfg    = 1'b1;
            end else begin
               state_d = DATA;
            end
         end else if (tmo_inc) begin
            if (iv_timeout != '0 && tmo_cnt_q + TMO_WD'(1) == iv_timeout) begin
               err_d     = 1'b1;
               lock_d    = 1'b0;
               tmo_cnt_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_WD'(1);
            end
         end
      end

      if (load_cfg) begin
         sync_word_d = iv_sync_word;
         sync_len_d  = iv_sync_len;
         line_pix_d  = iv_line_pix;
         align_d     = i_align_right;
      end

`ifdef AD9970_LINE_CNT_EN
      line_cnt_d = line_cnt_q;
      if (i_frame_start)    line_cnt_d = '0;
      else if (line_done_q) line_cnt_d = line_cnt_q + 16'd1;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= HUNT;
         match_cnt_q <= '0;
         pix_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         sync_word_q <= iv_sync_word;
         sync_len_q  <= iv_sync_len;
         line_pix_q  <= iv_line_pix;
         align_q     <= i_align_right;
         pix_q       <= '0;
         lval_q      <= 1'b0;
         done_pend_q <= 1'b0;
         line_done_q <= 1'b0;
         lock_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef AD9970_LINE_CNT_EN
         line_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         match_cnt_q <= match_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         sync_word_q <= sync_word_d;
         sync_len_q  <= sync_len_d;
         line_pix_q  <= line_pix_d;
         align_q     <= align_d;
         pix_q       <= pix_d;
         lval_q      <= lval_d;
         done_pend_q <= done_pend_d;
         line_done_q <= line_done_d;
         lock_q      <= lock_d;
         err_q       <= err_d;
`ifdef AD9970_LINE_CNT_EN
         line_cnt_q  <= line_cnt_d;
`endif
      end
   end

   assign bus.ov_pix_data = pix_q;
   assign bus.o_lval      = lval_q;
   assign bus.o_line_done = line_done_q;
   assign bus.o_sync_lock = lock_q;
   assign bus.o_sync_err  = err_q;
`ifdef AD9970_LINE_CNT_EN
   assign ov_line_cnt     = line_cnt_q;
`endif

endmodule

// File: tb/tb_ad9970_sync_decode.sv
// Scoreboard bench for ad9970_sync_decode: a word-level reference model queues expected
// pixels, line_done and sync_err events with their cycle; a monitor pops and compares.
module tb_ad9970_sync_decode;
   logic clk = 1'b0;
   logic reset;
   logic start;
   logic [15:0] sw;
   logic [2:0]  slen;
   logic [12:0] lpix;
   logic        align;
   logic [15:0] tmo;
`ifdef AD9970_LINE_CNT_EN
   logic        frame_start;
   logic [15:0] line_cnt;
`endif

   always #5 clk = ~clk;

   ad9970_sync_decode_if bus ();

   ad9970_sync_decode dut (
      .clk              (clk),
      .reset            (reset),
      .i_start_acquisit (start),
      .iv_sync_word     (sw),
      .iv_sync_len      (slen),
      .iv_line_pix      (lpix),
      .i_align_right    (align),
      .iv_timeout       (tmo),
`ifdef AD9970_LINE_CNT_EN
      .i_frame_start    (frame_start),
      .ov_line_cnt      (line_cnt),
`endif
      .bus              (bus)
   );

   typedef struct { logic [13:0] d; int c; } pix_t;
   pix_t pix_q[$];
   int   done_q[$];
   int   err_q[$];

   int n_tests = 0, n_fail = 0;
   int cyc = 0;
   int done_seen = 0, err_seen = 0;

   // reference model state (expected values after each edge)
   bit m_in_line;
   int m_left, m_run, m_idle;
   bit m_lock;
   int m_lock_at = -1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic logic [13:0] pixel(input logic [15:0] w);
      logic [15:0] t;
      t = align ? (w & 16'h3FFF) : (w >> 2);
      return t[13:0];
   endfunction

   // One deserializer word sampled at clock edge number e.
   function automatic void step(input bit st, input bit v, input logic [15:0] w, input int e);
      int need;
      if (m_lock_at == e) begin
         m_lock_at = -1;
         if (st) m_lock = 1'b1;
      end
      if (!st) begin
         if (done_q.size() > 0 && done_q[$] == e) void'(done_q.pop_back());
         m_in_line = 0; m_run = 0; m_idle = 0; m_lock = 0;
         return;
      end
      if (!v) return;
      if (m_in_line) begin
         pix_q.push_back('{pixel(w), e});
         m_left--;
         if (m_left == 0) begin
            m_in_line = 0;
            done_q.push_back(e + 1);
            m_lock_at = e + 1;
         end
         return;
      end
      need  = (slen == 0) ? 1 : int'(slen);
      m_run = (w == sw) ? m_run + 1 : 0;
      if (m_run == need) begin
         m_run = 0; m_idle = 0;
         if (lpix == 0) begin
            done_q.push_back(e + 1);
            m_lock_at = e + 1;
         end else begin
            m_in_line = 1;
            m_left    = int'(lpix);
         end
      end else begin
         m_idle++;
         if (tmo != 0 && m_idle == int'(tmo)) begin
            err_q.push_back(e);
            m_lock = 0;
            m_idle = 0;
         end
      end
   endfunction

   always @(negedge clk) begin
      pix_t p;
      while (pix_q.size() > 0 && pix_q[0].c < cyc) begin
         check("pix_missing", 32'(cyc), 32'(pix_q[0].c));
         void'(pix_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
         check("done_missing", 32'(cyc), 32'(done_q[0]));
         void'(done_q.pop_front());
      end
      while (err_q.size() > 0 && err_q[0] < cyc) begin
         check("err_missing", 32'(cyc), 32'(err_q[0]));
         void'(err_q.pop_front());
      end
      if (bus.o_lval) begin
         if (pix_q.size() == 0) check("lval_unexpected", 1, 0);
         else begin
            p = pix_q.pop_front();
            check("pix_data", 32'(bus.ov_pix_data), 32'(p.d));
            check("pix_cycle", 32'(cyc), 32'(p.c));
         end
      end
      if (bus.o_line_done) begin
         done_seen++;
         if (done_q.size() == 0) check("done_unexpected", 1, 0);
         else check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
      if (bus.o_sync_err) begin
         err_seen++;
         if (err_q.size() == 0) check("err_unexpected", 1, 0);
         else check("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
      end
   end

   task automatic drive(input bit st, input bit v, input logic [15:0] w);
      @(negedge clk);
      start = st;
      bus.i_deser_valid = v;
      bus.iv_deser_data = w;
      step(st, v, w, cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1, 0, 16'h0);
   endtask

   task automatic set_cfg(input logic [15:0] w, input logic [2:0] l, input logic [12:0] lp,
                          input logic al, input logic [15:0] to);
      sw = w; slen = l; lpix = lp; align = al; tmo = to;
      drive(0, 0, 16'h0);
      drive(0, 0, 16'h0);
   endtask

   task automatic send_sync(input int n);
      for (int i = 0; i < n; i++) drive(1, 1, sw);
   endtask

   // gap_mode: 0 none, 1 alternate valid/stall, 2 random stalls; drop_at<0 means no drop
   task automatic send_line(input int n, input bit ramp, input int gap_mode, input int drop_at);
      logic [15:0] w;
      for (int i = 0; i < n; i++) begin
         if (i == drop_at) begin
            drive(0, 0, 16'h0);
            return;
         end
         if (ramp) w = 16'(i);
         else w = ($urandom_range(9) == 0) ? sw : 16'($urandom);
         drive(1, 1, w);
         if (gap_mode == 1) drive(1, 0, 16'hFFFF);
         else if (gap_mode == 2) repeat ($urandom_range(2)) drive(1, 0, 16'($urandom));
      end
   endtask

   function automatic logic [15:0] noise();
      return sw ^ (16'd1 << $urandom_range(15));
   endfunction

`ifdef AD9970_LINE_CNT_EN
   task automatic pulse_frame();
      drive(1, 0, 16'h0);
      frame_start = 1'b1;
      drive(1, 0, 16'h0);
      frame_start = 1'b0;
   endtask
`endif

   initial begin
      int d0, e0, ne;
      reset = 1'b1; start = 1'b0;
      bus.i_deser_valid = 1'b0; bus.iv_deser_data = 16'h0;
      sw = 16'h8421; slen = 3'd7; lpix = 13'd1292; align = 1'b1; tmo = 16'd0;
`ifdef AD9970_LINE_CNT_EN
      frame_start = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_lval", 32'(bus.o_lval), 0);
      check("rst_pix", 32'(bus.ov_pix_data), 0);
      check("rst_done", 32'(bus.o_line_done), 0);
      check("rst_lock", 32'(bus.o_sync_lock), 0);
      check("rst_err", 32'(bus.o_sync_err), 0);
      reset = 1'b0;

      // full 1292-pixel ramp line after 7 sync words
      set_cfg(16'h8421, 3'd7, 13'd1292, 1'b1, 16'd0);
      d0 = done_seen;
      send_sync(7);
      send_line(1292, 1, 0, -1);
      idle(4);
      check("ramp_done_count", 32'(done_seen - d0), 1);
      check("ramp_lock", 32'(bus.o_sync_lock), 1);
      check("ramp_lock_model", 32'(bus.o_sync_lock), 32'(m_lock));

      // broken sync run is rejected, second run locks
      set_cfg(16'h8421, 3'd7, 13'd1292, 1'b1, 16'd1000);
      d0 = done_seen; e0 = err_seen;
      send_sync(6);
      drive(1, 1, 16'h1234);
      send_sync(7);
      send_line(1292, 0, 0, -1);
      idle(4);
      check("rerun_done_count", 32'(done_seen - d0), 1);
      check("rerun_no_err", 32'(err_seen - e0), 0);

      // valid toggling through the line
      set_cfg(16'h8421, 3'd7, 13'd1292, 1'b1, 16'd0);
      d0 = done_seen;
      send_sync(7);
      send_line(1292, 1, 1, -1);
      idle(4);
      check("gap_done_count", 32'(done_seen - d0), 1);

      // timeout at words 100 and 200 of 250
      set_cfg(16'h8421, 3'd7, 13'd1292, 1'b1, 16'd100);
      e0 = err_seen;
      for (int i = 0; i < 250; i++) drive(1, 1, 16'h1000 + 16'(i));
      idle(3);
      check("tmo_err_count", 32'(err_seen - e0), 2);
      check("tmo_lock", 32'(bus.o_sync_lock), 0);

      // acquisition dropped at pixel 500, then a clean line
      set_cfg(16'h8421, 3'd7, 13'd1292, 1'b1, 16'd0);
      d0 = done_seen;
      send_sync(7);
      send_line(1292, 1, 0, 500);
      drive(0, 0, 16'h0);
      check("drop_lval", 32'(bus.o_lval), 0);
      check("drop_lock", 32'(bus.o_sync_lock), 0);
      idle(3);
      check("drop_no_done", 32'(done_seen - d0), 0);
      send_sync(7);
      send_line(1292, 1, 0, -1);
      idle(4);
      check("redo_done_count", 32'(done_seen - d0), 1);

      // left alignment
      set_cfg(16'h8421, 3'd2, 13'd1, 1'b0, 16'd0);
      send_sync(2);
      drive(1, 1, 16'hABCD);
      idle(3);
      check("align_left", 32'(bus.ov_pix_data), 32'h2AF3);

      // zero-length line
      set_cfg(16'h8421, 3'd0, 13'd0, 1'b1, 16'd0);
      d0 = done_seen;
      send_sync(1);
      idle(4);
      check("zero_len_done", 32'(done_seen - d0), 1);
      check("zero_len_lock", 32'(bus.o_sync_lock), 1);

      // randomized configurations, noise, partial runs, stalls and drops
      for (int it = 0; it < 60; it++) begin
         set_cfg(16'($urandom), 3'($urandom_range(7)), 13'($urandom_range(24)),
                 1'($urandom_range(1)),
                 ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom_range(40, 3)));
         repeat ($urandom_range(6)) drive(1, 1'($urandom_range(1)), noise());
         ne = (slen == 0) ? 1 : int'(slen);
         if ($urandom_range(3) == 0) begin
            send_sync($urandom_range(ne - 1));
            drive(1, 1, noise());
         end
         send_sync(ne);
         send_line(int'(lpix), 0, $urandom_range(2),
                   ($urandom_range(9) == 0) ? $urandom_range(24) : -1);
         idle(2);
         check("rand_lock", 32'(bus.o_sync_lock), 32'(m_lock));
      end

`ifdef AD9970_LINE_CNT_EN
      set_cfg(16'h8421, 3'd1, 13'd3, 1'b1, 16'd0);
      pulse_frame();
      repeat (3) begin
         send_sync(1);
         send_line(3, 1, 0, -1);
         idle(2);
      end
      idle(2);
      check("line_cnt_3", 32'(line_cnt), 3);
      pulse_frame();
      idle(1);
      check("line_cnt_clr", 32'(line_cnt), 0);
`endif

      idle(5);
      check("pix_q_empty", 32'(pix_q.size()), 0);
      check("done_q_empty", 32'(done_q.size()), 0);
      check("err_q_empty", 32'(err_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
